fpadd_sched: RTL and testbench

Two-requester scheduler that shares one `fpadd_single` single-precision adder. It accepts operand pairs over valid/ready handshakes and arbitrates round-robin, issuing at most one addition per cycle. It tracks in-flight operations through the adder's fixed latency with a tag pipeline and returns each sum to its requester through a per-requester result FIFO with backpressure. It sits between the datapath clients and the `fpadd_single` instance.

---
 rtl/fpadd_sched_pkg.sv | 24 ++
 rtl/fpadd_res_fifo.sv | 70 +++++++
 rtl/fpadd_sched.sv | 182 ++++++++++++++++++
 tb/tb_fpadd_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_sched_pkg
// Purpose  : Shared defaults and types for the two-requester FP-add scheduler.
//            Holds the default adder latency and result-FIFO depth, the
//            requester-id width and the tag carried alongside each in-flight
//            addition.
// Revision : 1.0 - initial release
// ============================================================================
package fpadd_sched_pkg;

  localparam int LAT_DEFAULT   = 2;   // fp_a/fp_b stable -> fp_out valid, in edges
  localparam int DEPTH_DEFAULT = 4;   // entries per result FIFO
  localparam int ID_W          = 1;   // requester id width
  localparam int NREQ          = 2;   // number of requesters

  // One tag per pipeline stage: marks an addition in flight and its owner.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fpadd_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_res_fifo
// Purpose  : Synchronous result FIFO with occupancy output. Push and pop in
//            the same cycle leave the count unchanged. The head is forced to
//            zero while empty so the output is clean after reset and drain.
// Ports    : clk, reset (async, active-high)
//            push_i / push_data_i  - write one entry
//            pop_i                 - remove the head (ignored when empty)
//            valid_o / data_o      - non-empty flag and head entry
//            count_o               - current occupancy (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_res_fifo #(
  parameter int DEPTH = 4,    // power of two, >= 2
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fpadd_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_sched
// Purpose  : Shares one fixed-latency single-precision adder between two
//            requesters. Operand pairs are accepted over valid/ready with
//            round-robin arbitration (one issue per cycle), tracked through
//            the adder by a tag pipeline, and returned to their owner through
//            a per-requester result FIFO with backpressure.
// Ports    : clk, reset (async, active-high)
//            reqN_valid/reqN_a/reqN_b/reqN_ready - operand handshake, N=0,1
//            resN_valid/resN_data/resN_ready     - result handshake, N=0,1
//            fp_a, fp_b                          - registered adder operands
//            fp_out                              - adder result
//            busy                                - work in flight or buffered
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_sched
  import fpadd_sched_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        res0_valid,
  output logic [31:0] res0_data,
  input  logic        res0_ready,
  output logic        res1_valid,
  output logic [31:0] res1_data,
  input  logic        res1_ready,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  input  logic [31:0] fp_out,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;          // FIFO count width
  localparam int SW = $clog2(DEPTH + LAT + 2) + 1; // holds inflight + count

  logic [NREQ-1:0] req_valid, res_ready, credit, elig, grant;
  logic [NREQ-1:0] push, pop, res_valid;
  logic [31:0]     res_data [NREQ];
  logic [CW-1:0]   count    [NREQ];
  logic [SW-1:0]   inflight [NREQ];

  tag_t        tag_q [LAT+1];
  tag_t        tag0_d;
  logic        rr_q, rr_d;
  logic [31:0] fp_a_q, fp_a_d, fp_b_q, fp_b_d;
  logic        busy_d;

  assign req_valid = {req1_valid, req0_valid};
  assign res_ready = {res1_ready, res0_ready};

  // A requester may issue only if every result it could have outstanding,
  // including the new one, already has a reserved FIFO slot. This never
  // looks at resN_ready, so a slot frees only after the pop edge. A single
  // requester streaming alone needs DEPTH >= LAT+3 never to stall.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      inflight[r] = '0;
      for (int s = 0; s <= LAT; s++) begin
        if (tag_q[s].valid && (tag_q[s].id == ID_W'(r))) begin
          inflight[r] = inflight[r] + SW'(1);
        end
      end
      credit[r] = (inflight[r] + SW'(count[r])) < SW'(DEPTH);
    end
  end

  // Round-robin: rr_q names the requester that wins a tie.
  assign elig     = req_valid & credit;
  assign grant[0] = elig[0] & (~elig[1] | ~rr_q);
  assign grant[1] = elig[1] & (~elig[0] |  rr_q);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Issue: load operands, start a tag, hand the tie to the other requester.
  always_comb begin
    tag0_d = '0;
    rr_d   = rr_q;
    fp_a_d = fp_a_q;
    fp_b_d = fp_b_q;
    if (grant[1]) begin
      tag0_d.valid = 1'b1;
      tag0_d.id    = ID_W'(1);
      rr_d         = 1'b0;
      fp_a_d       = req1_a;
      fp_b_d       = req1_b;
    end else if (grant[0]) begin
      tag0_d.valid = 1'b1;
      tag0_d.id    = ID_W'(0);
      rr_d         = 1'b1;
      fp_a_d       = req0_a;
      fp_b_d       = req0_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= LAT; s++) begin
        tag_q[s] <= '0;
      end
      rr_q   <= 1'b0;
      fp_a_q <= '0;
      fp_b_q <= '0;
    end else begin
      tag_q[0] <= tag0_d;
      for (int s = 1; s <= LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      rr_q   <= rr_d;
      fp_a_q <= fp_a_d;
      fp_b_q <= fp_b_d;
    end
  end

  assign fp_a = fp_a_q;
  assign fp_b = fp_b_q;

  // The last tag stage lines up with fp_out holding that operation's sum.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      push[r] = tag_q[LAT].valid && (tag_q[LAT].id == ID_W'(r));
    end
  end

  assign pop = res_valid & res_ready;

  fpadd_res_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_res_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push[0]),
    .push_data_i (fp_out),
    .pop_i       (pop[0]),
    .valid_o     (res_valid[0]),
    .data_o      (res_data[0]),
    .count_o     (count[0])
  );

  fpadd_res_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_res_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push[1]),
    .push_data_i (fp_out),
    .pop_i       (pop[1]),
    .valid_o     (res_valid[1]),
    .data_o      (res_data[1]),
    .count_o     (count[1])
  );

  assign res0_valid = res_valid[0];
  assign res1_valid = res_valid[1];
  assign res0_data  = res_data[0];
  assign res1_data  = res_data[1];

  always_comb begin
    busy_d = |res_valid;
    for (int s = 0; s <= LAT; s++) begin
      if (tag_q[s].valid) busy_d = 1'b1;
    end
  end

  assign busy = busy_d;

endmodule
`default_nettype wire

// File: tb/tb_fpadd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpadd_sched
// Purpose  : Directed bench for fpadd_sched with a two-stage behavioural
//            stand-in for the shared adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpadd_sched;

  logic        clk, reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res0_valid, res1_valid, res0_ready, res1_ready;
  logic [31:0] res0_data, res1_data;
  logic [31:0] fp_a, fp_b, fp_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int rcv0  = 0;
  int rcv1  = 0;

  fpadd_sched #(.LAT(2), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res0_valid (res0_valid),
    .res0_data  (res0_data),
    .res0_ready (res0_ready),
    .res1_valid (res1_valid),
    .res1_data  (res1_data),
    .res1_ready (res1_ready),
    .fp_a       (fp_a),
    .fp_b       (fp_b),
    .fp_out     (fp_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: hand-computed sums for the vectors used, integer sum
  // otherwise (distinct, order-revealing values for streaming tests).
  function automatic logic [31:0] fpsum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1.0 + 2.0
      {32'h3FC00000, 32'h40200000}: return 32'h40800000; // 1.5 + 2.5
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1.0 + 1.0
      {32'h7F800000, 32'hFF800000}: return 32'h7FC00000; // +inf + -inf
      default:                      return a + b;
    endcase
  endfunction

  logic [31:0] add_a_q, add_b_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a_q <= '0;
      add_b_q <= '0;
      fp_out  <= '0;
    end else begin
      add_a_q <= fp_a;
      add_b_q <= fp_b;
      fp_out  <= fpsum(add_a_q, add_b_q);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Scoreboard: per-requester expected results in issue order.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  always @(negedge clk) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) exp_q0.push_back(fpsum(req0_a, req0_b));
      if (req1_valid && req1_ready) exp_q1.push_back(fpsum(req1_a, req1_b));
      if (res0_valid && res0_ready) begin
        if (exp_q0.size() == 0) check_eq("unexp_res0", 32'(res0_valid), 0);
        else begin
          check_eq("res0_data", res0_data, exp_q0.pop_front());
          rcv0++;
        end
      end
      if (res1_valid && res1_ready) begin
        if (exp_q1.size() == 0) check_eq("unexp_res1", 32'(res1_valid), 0);
        else begin
          check_eq("res1_data", res1_data, exp_q1.pop_front());
          rcv1++;
        end
      end
      if (dut.u_res_fifo0.count_o > 3'd4) check_eq("ovf0", 32'(dut.u_res_fifo0.count_o), 4);
      if (dut.u_res_fifo1.count_o > 3'd4) check_eq("ovf1", 32'(dut.u_res_fifo1.count_o), 4);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int g0, g1, base0, base1;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0;
    res0_ready = 1'b0; res1_ready = 1'b0;

    // ---- reset state ----
    tick();
    check_eq("rst_fp_a",   fp_a, 0);
    check_eq("rst_fp_b",   fp_b, 0);
    check_eq("rst_busy",   32'(busy), 0);
    check_eq("rst_res0_v", 32'(res0_valid), 0);
    check_eq("rst_res1_v", 32'(res1_valid), 0);
    check_eq("rst_res0_d", res0_data, 0);
    check_eq("rst_res1_d", res1_data, 0);
    check_eq("rst_rdy0",   32'(req0_ready), 1);
    check_eq("rst_rdy1",   32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;

    // ---- single op, latency 3 ----
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    @(negedge clk);
    check_eq("one_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("one_lat_lo", 32'(res0_valid), 0);
      if (k == 0) begin
        check_eq("one_fp_a", fp_a, 32'h3F800000);
        check_eq("one_fp_b", fp_b, 32'h40000000);
      end
      tick();
    end
    res0_ready = 1'b1;
    @(negedge clk);
    check_eq("one_res0_v", 32'(res0_valid), 1);
    check_eq("one_res0_d", res0_data, 32'h40400000);
    check_eq("one_res1_v", 32'(res1_valid), 0);
    tick();
    res0_ready = 1'b0;
    @(negedge clk);
    check_eq("one_res0_pop", 32'(res0_valid), 0);
    check_eq("one_busy",     32'(busy), 0);

    // ---- contention: grants alternate starting with 0 ----
    tick();
    do_reset();
    base0 = rcv0; base1 = rcv1;
    res0_ready = 1'b1; res1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40200000;
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("ctn_rdy0", 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
      check_eq("ctn_rdy1", 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) tick();
    check_eq("ctn_rcv0", rcv0, base0 + 3);
    check_eq("ctn_rcv1", rcv1, base1 + 3);
    check_eq("ctn_busy", 32'(busy), 0);

    // ---- backpressure on requester 1 ----
    do_reset();
    base0 = rcv0; base1 = rcv1;
    g0 = 0; g1 = 0;
    res0_ready = 1'b1; res1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req1_valid = 1'b1; req1_a = 32'h00000010; req1_b = 32'h00000100;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (req1_ready) g1++;
      if (req0_ready) g0++;
      if (k >= 8) check_eq("bp_rdy1_lo", 32'(req1_ready), 0);
      tick();
      req1_a = 32'h00000010 + g1;
    end
    req0_valid = 1'b0;
    check_eq("bp_grants1", g1, 4);
    @(negedge clk);
    check_eq("bp_cnt1",   32'(dut.u_res_fifo1.count_o), 4);
    check_eq("bp_head1",  res1_data, 32'h00000110);
    check_eq("bp_rdy1_f", 32'(req1_ready), 0);
    tick();
    res1_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rdy1_pop", 32'(req1_ready), 0);
    tick();
    @(negedge clk);
    check_eq("bp_regrant", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    repeat (10) tick();
    check_eq("bp_rcv1", rcv1, base1 + 5);
    check_eq("bp_rcv0", rcv0, base0 + g0);
    check_eq("bp_busy", 32'(busy), 0);

    // ---- simultaneous push and pop at count 2 ----
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h00000020; req0_b = 32'h00001000;
    tick();
    req0_a = 32'h00000021;
    tick();
    req0_a = 32'h00000022;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    res0_ready = 1'b1;
    @(negedge clk);
    check_eq("pp_cnt_before", 32'(dut.u_res_fifo0.count_o), 2);
    check_eq("pp_head_before", res0_data, 32'h00001020);
    tick();
    @(negedge clk);
    check_eq("pp_cnt_after", 32'(dut.u_res_fifo0.count_o), 2);
    check_eq("pp_head_after", res0_data, 32'h00001021);
    repeat (4) tick();
    check_eq("pp_drained", 32'(dut.u_res_fifo0.count_o), 0);

    // ---- reset mid-flight ----
    do_reset();
    res0_ready = 1'b1; res1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40200000;
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("mrst_fp_a", fp_a, 0);
    check_eq("mrst_fp_b", fp_b, 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_res_v", {30'b0, res1_valid, res0_valid}, 0);
    check_eq("mrst_res0_d", res0_data, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("mrst_nores", {30'b0, res1_valid, res0_valid}, 0);
      check_eq("mrst_idle",  32'(busy), 0);
      tick();
    end

    // ---- special values pass through unchanged ----
    res0_ready = 1'b0; res1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h7F800000; req1_b = 32'hFF800000;
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("sp_res1_v", 32'(res1_valid), 1);
    check_eq("sp_res1_d", res1_data, 32'h7FC00000);
    check_eq("sp_res0_v", 32'(res0_valid), 0);
    tick();
    res1_ready = 1'b1;
    repeat (2) tick();
    check_eq("sp_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
